instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Sequential instruction-fetch front end for the single-issue MIPS core. It owns the program counter and requests words from instruction memory over a req/ack handshake. It presents each fetched word, with its OpCode/Funct fields, to the control decoder. When the datapath accepts the word, it takes that instruction's PCSrc/Branch decisions back and computes the next PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- ImemReq  out  1  fetch request; held high until ImemAck.
- ImemAddr  out  32  word address of the request; stable while ImemReq is high.
- ImemAck  in  1  memory completion; ImemRData is valid in the same cycle.
- ImemRData  in  32  fetched instruction word.
- Instr  out  32  registered instruction presented downstream.
- OpCode  out  6  Instr[31:26].
- Funct  out  6  Instr[5:0].
- PCPlus4  out  32  fetch address of Instr plus 4.
- InstrValid  out  1  Instr/PCPlus4 are valid.
- DecReady  in  1  downstream accepts Instr when InstrValid && DecReady.
- PCSrc  in  2  from control for the presented Instr: 00 sequential/branch, 01 j/jal, 10 jr/jalr, 11 treated as 00.
- Branch  in  1  from control; beq.
- Zero  in  1  ALU zero flag for the presented Instr.
- RegRs  in  32  rs register value, used as the jr/jalr target.
- AddrError  out  1  sticky; a misaligned target was computed.
- InstrCount  out  32  count of accepted instructions.

## Operation
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Next-PC selection. Evaluated only in the accept cycle, using the inputs sampled in that cycle. Priority order:
  - PCSrc==01: {PCPlus4[31:28], Instr[25:0], 2'b00}.
  - PCSrc==10: RegRs.
  - Branch && Zero: PCPlus4 + ({{14{Instr[15]}}, Instr[15:0], 2'b00}), modulo 2^32.
  - Otherwise: PCPlus4.
- Address error. If the selected target has bits [1:0] != 0, AddrError sets and the FSM enters HALT. No further requests are issued.
- States:
  - FETCH: ImemReq=1, ImemAddr=PC. On ImemAck, latch ImemRData into Instr and PC+4 into PCPlus4, then go to HOLD.
  - HOLD: InstrValid=1. On DecReady: update PC to the next PC, increment InstrCount, then go to FETCH (or to HALT on misalignment). Without DecReady, stay in HOLD with all outputs stable.
  - HALT: ImemReq=0, InstrValid=0. Left only by reset.
- Counter: InstrCount wraps from 32'hFFFF_FFFF to 0.
- PC arithmetic wraps modulo 2^32. PC 32'hFFFF_FFFC sequences to 32'h0000_0000 with no error.
- Ignored inputs: PCSrc, Branch, Zero and RegRs are ignored outside the accept cycle. ImemAck is ignored outside FETCH.

## Timing
- Reset values: state FETCH, PC=RESET_PC, ImemReq=0, ImemAddr=RESET_PC, Instr=0, OpCode=0, Funct=0, PCPlus4=0, InstrValid=0, AddrError=0, InstrCount=0.
- ImemReq rises in the first clk edge after reset_n deasserts.
- ImemAck may arrive in the same cycle ImemReq first rises. That gives a minimum fetch latency of 1 cycle.
- InstrValid rises on the edge that samples ImemAck.
- Accept cycle N: ImemReq rises at edge N+1 with the new ImemAddr. Best-case throughput is one instruction per 2 cycles.
- ImemReq falls on the edge that samples ImemAck. ImemAddr holds its value until that edge.
- Reset mid-operation: all state returns to reset values immediately. The outstanding memory request is abandoned, and the memory side must tolerate a dropped request.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package mips_pkg:
  - fetch state enum (FETCH, HOLD, HALT).
  - PCSrc encodings: PCSRC_SEQ=2'b00, PCSRC_JUMP=2'b01, PCSRC_JR=2'b10.
  - opcode field slice constants.
- One sub-module, next_pc_calc: purely combinational. Inputs: PCPlus4, Instr, PCSrc, Branch, Zero, RegRs. Outputs: NextPC and Misaligned.
- The FSM, PC register, instruction register and counter live in instr_fetch_unit.

## Test plan
- Reset sequencing: release reset_n, ack on the first request cycle with 32'h0000_0020 (add). Expect ImemAddr=0 and ImemReq high at edge 1. At edge 2: InstrValid=1, OpCode=0, Funct=6'h20, PCPlus4=4.
- Backpressure: hold DecReady=0 for 5 cycles. Instr/InstrValid stay stable and no new ImemReq is issued. DecReady=1 then gives ImemAddr=4 on the next edge and InstrCount=1.
- Branch: present beq (32'h1000_FFFF) at PC 8 with Branch=1, Zero=1. Next ImemAddr=32'h0000_0008. Repeat with Zero=0: expect 32'h0000_000C.
- Jumps:
  - j with Instr[25:0]=26'h000_0100 at PC 32'h1000_0000: next ImemAddr=32'h1000_0400.
  - jr with RegRs=32'h0000_0040: next ImemAddr=32'h0000_0040.
- Misaligned jr: RegRs=32'h0000_0042. AddrError=1, ImemReq stays 0, InstrValid=0. State holds until reset_n pulses low, after which fetch restarts at RESET_PC.
- Asynchronous reset mid-FETCH: assert reset_n low between edges while ImemReq=1. ImemReq=0 and all outputs take their reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end.
// Fetch FSM states, PCSrc encodings and instruction field positions.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_JUMP = 2'b01;
    localparam logic [1:0] PCSRC_JR   = 2'b10;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    function automatic logic [31:0] branch_offset(
        input logic [15:0] imm
    );
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/ack bus.
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if;

    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemRData;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemAck,
        input  ImemRData
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemAck,
        output ImemRData
    );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC select for the accepted instruction.
// Jump beats jr beats taken branch beats sequential.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] PCPlus4,
    input  logic [31:0] Instr,
    input  logic [1:0]  PCSrc,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [31:0] RegRs,
    output logic [31:0] NextPC,
    output logic        Misaligned
);

    logic is_jump;
    logic is_jr;
    logic take_br;
    logic unused_op;

    assign unused_op = ^Instr[OPCODE_MSB:OPCODE_LSB];

    always_comb begin
        is_jump = (PCSrc == PCSRC_JUMP);
        is_jr   = (PCSrc == PCSRC_JR);
        // PCSrc 11 behaves like the sequential encoding
        take_br = (PCSrc inside {PCSRC_SEQ, 2'b11})
                  && Branch && Zero;
        NextPC  = PCPlus4;
        unique case (1'b1)
            is_jump: NextPC = {PCPlus4[31:28],
                               Instr[25:0], 2'b00};
            is_jr:   NextPC = RegRs;
            take_br: NextPC = PCPlus4
                              + branch_offset(Instr[15:0]);
            default: NextPC = PCPlus4;
        endcase
        Misaligned = (NextPC[1:0] != 2'b00);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential fetch front end: PC, fetch FSM, instruction
// register and accepted-instruction counter.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    instr_fetch_unit_if.master         imem,
    output logic [31:0]                Instr,
    output logic [5:0]                 OpCode,
    output logic [5:0]                 Funct,
    output logic [31:0]                PCPlus4,
    output logic                       InstrValid,
    input  logic                       DecReady,
    input  logic [1:0]                 PCSrc,
    input  logic                       Branch,
    input  logic                       Zero,
    input  logic [31:0]                RegRs,
    output logic                       AddrError,
    output logic [31:0]                InstrCount
);

    fetch_state_t state;
    fetch_state_t state_nxt;

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pcp4_q;
    logic [31:0] cnt_q;
    logic        req_q;
    logic        vld_q;
    logic        err_q;

    logic [31:0] next_pc;
    logic        misaligned;
    logic        ack_take;
    logic        accept;

    next_pc_calc u_next_pc (
        .PCPlus4    (pcp4_q),
        .Instr      (instr_q),
        .PCSrc      (PCSrc),
        .Branch     (Branch),
        .Zero       (Zero),
        .RegRs      (RegRs),
        .NextPC     (next_pc),
        .Misaligned (misaligned)
    );

    // an ack only counts once the request is actually on the bus
    assign ack_take = (state == FETCH) && req_q && imem.ImemAck;
    assign accept   = (state == HOLD) && DecReady;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FETCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH: if (ack_take) state_nxt = HOLD;
            HOLD:  if (accept)
                       state_nxt = misaligned ? HALT : FETCH;
            HALT:  state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    // outputs are registered from the upcoming state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pcp4_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            req_q <= (state_nxt == FETCH);
            vld_q <= (state_nxt == HOLD);
            if (ack_take) begin
                instr_q <= imem.ImemRData;
                pcp4_q  <= pc_q + 32'd4;
            end
            if (accept) begin
                pc_q  <= next_pc;
                cnt_q <= cnt_q + 32'd1;
                if (misaligned) err_q <= 1'b1;
            end
        end
    end

    assign imem.ImemReq  = req_q;
    assign imem.ImemAddr = pc_q;
    assign Instr         = instr_q;
    assign OpCode        = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign Funct         = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign PCPlus4       = pcp4_q;
    assign InstrValid    = vld_q;
    assign AddrError     = err_q;
    assign InstrCount    = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder
// plus expected-fetch-address scoreboard.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] Instr;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic [31:0] PCPlus4;
    logic        InstrValid;
    logic        DecReady;
    logic [1:0]  PCSrc;
    logic        Branch;
    logic        Zero;
    logic [31:0] RegRs;
    logic        AddrError;
    logic [31:0] InstrCount;

    instr_fetch_unit_if imem ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem       (imem.master),
        .Instr      (Instr),
        .OpCode     (OpCode),
        .Funct      (Funct),
        .PCPlus4    (PCPlus4),
        .InstrValid (InstrValid),
        .DecReady   (DecReady),
        .PCSrc      (PCSrc),
        .Branch     (Branch),
        .Zero       (Zero),
        .RegRs      (RegRs),
        .AddrError  (AddrError),
        .InstrCount (InstrCount)
    );

    localparam logic [31:0] JR_W = 32'h0040_0008;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_instr;
    logic [31:0] m_pcp4;
    logic [31:0] m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1);
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] word, input int lat);
        int          n;
        logic [31:0] ea;
        n = 0;
        while (!imem.ImemReq && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_hi", {31'd0, imem.ImemReq}, 32'd1);
        ea = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("addr", imem.ImemAddr, ea);
        chk("vld_lo", {31'd0, InstrValid}, 32'd0);
        repeat (lat) begin
            @(posedge clk); #1;
            chk("addr_hold", imem.ImemAddr, ea);
        end
        imem.ImemAck   = 1'b1;
        imem.ImemRData = word;
        @(posedge clk); #1;
        imem.ImemAck   = 1'b0;
        imem.ImemRData = $urandom;
        chk("req_fall", {31'd0, imem.ImemReq}, 32'd0);
        chk("vld_hi", {31'd0, InstrValid}, 32'd1);
        chk("instr", Instr, word);
        chk("opcode", {26'd0, OpCode}, {26'd0, word[31:26]});
        chk("funct", {26'd0, Funct}, {26'd0, word[5:0]});
        chk("pcplus4", PCPlus4, ea + 32'd4);
        m_instr = word;
        m_pcp4  = ea + 32'd4;
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            imem.ImemAck   = 1'b1;
            imem.ImemRData = $urandom;
            PCSrc          = 2'($urandom);
            RegRs          = $urandom;
            @(posedge clk); #1;
            chk("bp_vld", {31'd0, InstrValid}, 32'd1);
            chk("bp_req", {31'd0, imem.ImemReq}, 32'd0);
            chk("bp_instr", Instr, m_instr);
        end
        imem.ImemAck = 1'b0;
    endtask

    task automatic accept(input logic [1:0] ps, input logic br,
                          input logic z, input logic [31:0] rs);
        logic [31:0] t;
        logic signed [31:0] off;
        off = 32'(signed'(m_instr[15:0])) * 4;
        if (ps == 2'b01)      t = {m_pcp4[31:28], m_instr[25:0], 2'b00};
        else if (ps == 2'b10) t = rs;
        else if (br && z)     t = m_pcp4 + off;
        else                  t = m_pcp4;
        if (t[1:0] == 2'b00) exp_q.push_back(t);
        DecReady = 1'b1;
        PCSrc    = ps;
        Branch   = br;
        Zero     = z;
        RegRs    = rs;
        @(posedge clk); #1;
        DecReady = 1'b0;
        PCSrc    = 2'($urandom);
        Branch   = 1'($urandom);
        Zero     = 1'($urandom);
        RegRs    = $urandom;
        m_cnt    = m_cnt + 32'd1;
        chk("count", InstrCount, m_cnt);
        chk("acc_vld", {31'd0, InstrValid}, 32'd0);
        if (t[1:0] != 2'b00) begin
            chk("err_set", {31'd0, AddrError}, 32'd1);
            chk("halt_req", {31'd0, imem.ImemReq}, 32'd0);
        end else begin
            chk("err_clr", {31'd0, AddrError}, 32'd0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, {31'd0, imem.ImemReq}, 32'd0);
        chk({tag, "_addr"}, imem.ImemAddr, 32'd0);
        chk({tag, "_instr"}, Instr, 32'd0);
        chk({tag, "_op"}, {26'd0, OpCode}, 32'd0);
        chk({tag, "_fn"}, {26'd0, Funct}, 32'd0);
        chk({tag, "_pc4"}, PCPlus4, 32'd0);
        chk({tag, "_vld"}, {31'd0, InstrValid}, 32'd0);
        chk({tag, "_err"}, {31'd0, AddrError}, 32'd0);
        chk({tag, "_cnt"}, InstrCount, 32'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        DecReady       = 1'b0;
        PCSrc          = 2'b00;
        Branch         = 1'b0;
        Zero           = 1'b0;
        RegRs          = '0;
        imem.ImemAck   = 1'b0;
        imem.ImemRData = '0;
        m_cnt          = '0;
        m_instr        = '0;
        m_pcp4         = '0;
        @(posedge clk); #2;
        chk_reset_vals("rst");
        reset_n = 1'b1;
        exp_q.push_back(32'h0000_0000);

        fetch(32'h0000_0020, 0);
        stall(5);
        accept(2'b00, 1'b0, 1'b0, 32'h0);
        fetch(32'h0000_0000, $urandom_range(0, 2));
        accept(2'b11, 1'b1, 1'b0, 32'h1234_5678);
        fetch(32'h1000_FFFF, $urandom_range(0, 2));
        accept(2'b00, 1'b1, 1'b1, 32'h0);
        fetch(32'h1000_FFFF, $urandom_range(0, 2));
        accept(2'b00, 1'b1, 1'b0, 32'h0);
        fetch(JR_W, $urandom_range(0, 2));
        accept(2'b10, 1'b0, 1'b0, 32'h1000_0000);
        fetch(32'h0800_0100, $urandom_range(0, 2));
        accept(2'b01, 1'b1, 1'b1, 32'h0000_0080);
        fetch(JR_W, $urandom_range(0, 2));
        accept(2'b10, 1'b1, 1'b1, 32'h0000_0040);
        fetch(JR_W, $urandom_range(0, 2));
        accept(2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC);
        fetch(32'h0000_0020, $urandom_range(0, 2));
        accept(2'b00, 1'b0, 1'b0, 32'h0);
        fetch(JR_W, $urandom_range(0, 2));
        accept(2'b10, 1'b0, 1'b0, 32'h0000_0042);

        for (int i = 0; i < 4; i++) begin
            imem.ImemAck = 1'($urandom);
            DecReady     = 1'($urandom);
            @(posedge clk); #1;
            chk("halt_req", {31'd0, imem.ImemReq}, 32'd0);
            chk("halt_vld", {31'd0, InstrValid}, 32'd0);
            chk("halt_err", {31'd0, AddrError}, 32'd1);
        end
        imem.ImemAck = 1'b0;
        DecReady     = 1'b0;

        #2 reset_n = 1'b0;
        #1 chk_reset_vals("rst2");
        @(posedge clk); #2;
        reset_n = 1'b1;
        exp_q.delete();
        exp_q.push_back(32'h0000_0000);
        m_cnt = '0;
        fetch(32'h0000_0020, 1);
        accept(2'b00, 1'b0, 1'b0, 32'h0);
        chk("pre_async_req", {31'd0, imem.ImemReq}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("async");
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
